// File: rtl/service_scheduler_pkg.sv
// Shared definitions for the service scheduler: FSM encoding, alarm service index
// and default run-time limit.
package service_scheduler_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ALARM_SVC = 3;
    localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 16'd1000;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GRANT = 4'b0010,
        RUN   = 4'b0100,
        DRAIN = 4'b1000
    } state_e;

endpackage

// File: rtl/service_scheduler_rr_picker.sv
// Combinational round-robin picker: first requesting index after last_id, wrapping.
module rr_picker #(
    parameter int unsigned N_SVC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_SVC-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    logic [ID_W-1:0] cand;

    always_comb begin
        id    = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_SVC; k++) begin
            cand = ID_W'((32'(last_id) + k) % N_SVC);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/service_scheduler.sv
// Grants one service at a time (round-robin, alarm has priority), routes the mode
// push to it and forces release after a run-time limit.
module service_scheduler
    import service_scheduler_pkg::*;
#(
    parameter int unsigned       N_SVC   = 4,
    parameter logic [CNT_W-1:0]  TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned      ID_W    = $clog2(N_SVC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SVC-1:0]  svc_req,
    input  logic [N_SVC-1:0]  finish,
    input  logic              push_m,
    input  logic              alarm_armed,
    input  logic [15:0]       current,
    input  logic [15:0]       alarm,
    output logic [N_SVC-1:0]  svc_en,
    output logic [N_SVC-1:0]  push_out,
    output logic [ID_W-1:0]   active_id,
    output logic              busy,
    output logic              timeout_flag
);

    localparam logic [ID_W-1:0] ALARM_ID = ID_W'(ALARM_SVC);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              match_prev_q, match_prev_d;
    logic              push_prev_q, push_prev_d;
    logic [N_SVC-1:0]  svc_en_q, svc_en_d;
    logic [N_SVC-1:0]  push_out_q, push_out_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              push_rise_c;
    logic              match_c;
    logic              alarm_set_c;
    logic [ID_W-1:0]   pick_id_c;
    logic              pick_valid_c;

    rr_picker #(.N_SVC(N_SVC), .ID_W(ID_W)) u_rr_picker (
        .req     (svc_req),
        .last_id (last_id_q),
        .id      (pick_id_c),
        .valid   (pick_valid_c)
    );

    always_comb begin
        push_rise_c  = push_m & ~push_prev_q;
        match_c      = (current == alarm);
        alarm_set_c  = alarm_armed & match_c & ~match_prev_q;

        state_d      = state_q;
        id_d         = id_q;
        last_id_d    = last_id_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q | alarm_set_c;
        timeout_d    = 1'b0;
        push_prev_d  = push_m;
        match_prev_d = match_c;

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = GRANT;
                    id_d    = ALARM_ID;
                    pend_d  = alarm_set_c;
                end else if (pick_valid_c) begin
                    state_d = GRANT;
                    id_d    = pick_id_c;
                end
            end
            GRANT: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
                // Exit causes in priority order; only the last one is a forced release.
                if (finish[id_q] || !svc_req[id_q] || (pend_q && id_q != ALARM_ID)) begin
                    state_d = DRAIN;
                end else if (cnt_q == TIMEOUT - CNT_W'(1)) begin
                    state_d   = DRAIN;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                state_d   = IDLE;
                last_id_d = id_q;
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == GRANT) || (state_d == RUN);
        svc_en_d = '0;
        if (busy_d) svc_en_d[id_d] = 1'b1;

        // Pushes reach the service only if it is still running next cycle.
        push_out_d = '0;
        if (state_q == RUN && state_d == RUN && push_rise_c) push_out_d[id_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            id_q         <= '0;
            last_id_q    <= ID_W'(N_SVC - 1);
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            match_prev_q <= 1'b1;
            push_prev_q  <= 1'b0;
            svc_en_q     <= '0;
            push_out_q   <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            last_id_q    <= last_id_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            match_prev_q <= match_prev_d;
            push_prev_q  <= push_prev_d;
            svc_en_q     <= svc_en_d;
            push_out_q   <= push_out_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign svc_en       = svc_en_q;
    assign push_out     = push_out_q;
    assign active_id    = id_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_service_scheduler.sv
// Self-checking bench for service_scheduler: vector table, directed corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_service_scheduler;

    localparam int unsigned N  = 4;
    localparam logic [15:0] TO = 16'd20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  svc_req, finish, svc_en, push_out;
    logic        push_m, alarm_armed, busy, timeout_flag;
    logic [15:0] current, alarm;
    logic [1:0]  active_id;

    int checks = 0;
    int errors = 0;

    service_scheduler #(.N_SVC(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .svc_req      (svc_req),
        .finish       (finish),
        .push_m       (push_m),
        .alarm_armed  (alarm_armed),
        .current      (current),
        .alarm        (alarm),
        .svc_en       (svc_en),
        .push_out     (push_out),
        .active_id    (active_id),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] fin;
        logic       push;
        logic [3:0] en;
        logic       busy;
        logic [3:0] pout;
    } vec_t;

    vec_t tbl [11];

    // reference model: owner<0 means nobody holds the grant; age 0 = grant cycle,
    // age k>=1 = k-th RUN cycle
    int         m_owner, m_age, m_last;
    bit         m_drain, m_pend, m_prev_eq, m_prev_push;
    logic [3:0] e_en, e_push;
    bit         e_busy, e_tf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        svc_req     = '0;
        finish      = '0;
        push_m      = 1'b0;
        alarm_armed = 1'b0;
        current     = 16'd0;
        alarm       = 16'd5;
        tick();
        reset = 1'b0;
    endtask

    task automatic model_init();
        m_owner = -1; m_age = 0; m_last = 3;
        m_drain = 0; m_pend = 0; m_prev_eq = 0; m_prev_push = 0;
        e_en = '0; e_push = '0; e_busy = 0; e_tf = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] f, input logic p,
                              input logic armed, input logic [15:0] cur, input logic [15:0] alm);
        bit eq, set, new_pend, found, preempt;
        eq       = (cur == alm);
        set      = armed && eq && !m_prev_eq;
        new_pend = m_pend || set;
        e_push   = '0;
        e_tf     = 0;
        if (m_drain) begin
            m_drain = 0;
        end else if (m_owner < 0) begin
            if (m_pend) begin
                m_owner = 3; m_age = 0; new_pend = set;
            end else begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && r[(m_last + k) % 4]) begin
                        found = 1; m_owner = (m_last + k) % 4; m_age = 0;
                    end
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            preempt = m_pend && (m_owner != 3);
            if (f[m_owner] || !r[m_owner] || preempt || m_age == int'(TO)) begin
                e_tf    = !f[m_owner] && r[m_owner] && !preempt;
                m_last  = m_owner;
                m_owner = -1;
                m_drain = 1;
            end else begin
                m_age++;
                if (p && !m_prev_push) e_push = 4'b0001 << m_owner;
            end
        end
        m_pend      = new_pend;
        m_prev_eq   = eq;
        m_prev_push = p;
        e_busy      = (m_owner >= 0);
        e_en        = e_busy ? (4'b0001 << m_owner) : 4'b0000;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int exp_id;

        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000};
        tbl[2]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010};
        tbl[4]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0000};
        tbl[5]  = '{4'b0010, 4'b0100, 1'b1, 4'b0010, 1'b1, 4'b0000};
        tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

        // reset values
        reset = 1'b1; svc_req = '0; finish = '0; push_m = 1'b0;
        alarm_armed = 1'b0; current = 16'd0; alarm = 16'd5;
        tick();
        chk("reset svc_en", 32'(svc_en), 0);
        chk("reset push_out", 32'(push_out), 0);
        chk("reset active_id", 32'(active_id), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset timeout_flag", 32'(timeout_flag), 0);
        reset = 1'b0;

        // vector table: grant latency, push routing, finish release, push in idle
        for (int i = 0; i < 11; i++) begin
            svc_req = tbl[i].req; finish = tbl[i].fin; push_m = tbl[i].push;
            tick();
            chk($sformatf("vec%0d svc_en", i), 32'(svc_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d push_out", i), 32'(push_out), 32'(tbl[i].pout));
        end

        // round-robin alternation between services 0 and 1
        for (int g = 0; g < 4; g++) begin
            exp_id = (g % 2 == 0) ? 0 : 1;
            svc_req = 4'b0011; finish = '0;
            tick();
            chk($sformatf("rr%0d grant", g), 32'(svc_en), 32'(4'b0001 << exp_id));
            chk($sformatf("rr%0d active_id", g), 32'(active_id), 32'(exp_id));
            repeat (5) tick();
            chk($sformatf("rr%0d run", g), 32'(svc_en), 32'(4'b0001 << exp_id));
            finish = 4'b0001 << exp_id;
            tick();
            chk($sformatf("rr%0d drain en", g), 32'(svc_en), 0);
            chk($sformatf("rr%0d drain busy", g), 32'(busy), 0);
            finish = '0;
            tick();
            chk($sformatf("rr%0d idle gap", g), 32'(svc_en), 0);
        end

        // alarm preemption, then pending cleared, then finish beats alarm
        do_reset();
        alarm = 16'd10; alarm_armed = 1'b1; svc_req = 4'b1011;
        tick();
        chk("alm grant0", 32'(svc_en), 32'(4'b0001));
        tick();
        current = 16'd9;  tick();
        current = 16'd10; tick();
        chk("alm match run", 32'(svc_en), 32'(4'b0001));
        tick();
        chk("alm preempt drain", 32'(svc_en), 0);
        tick();
        chk("alm idle", 32'(svc_en), 0);
        tick();
        chk("alm grant3", 32'(svc_en), 32'(4'b1000));
        chk("alm active_id", 32'(active_id), 3);
        tick();
        finish = 4'b1000; tick();
        finish = '0;      tick();
        tick();
        chk("alm pending cleared", 32'(svc_en), 32'(4'b0001));
        tick();
        current = 16'd11; tick();
        current = 16'd10; finish = 4'b0001; tick();
        chk("finish wins drain", 32'(svc_en), 0);
        chk("finish wins no timeout", 32'(timeout_flag), 0);
        finish = '0; tick();
        tick();
        chk("pending served", 32'(svc_en), 32'(4'b1000));

        // forced release after TO run cycles
        do_reset();
        svc_req = 4'b0100;
        tick();
        chk("to grant", 32'(svc_en), 32'(4'b0100));
        for (int k = 1; k <= int'(TO); k++) begin
            tick();
            chk($sformatf("to run%0d en", k), 32'(svc_en), 32'(4'b0100));
            chk($sformatf("to run%0d flag", k), 32'(timeout_flag), 0);
        end
        tick();
        chk("to release en", 32'(svc_en), 0);
        chk("to release flag", 32'(timeout_flag), 1);
        tick();
        chk("to flag one cycle", 32'(timeout_flag), 0);
        chk("to idle gap", 32'(svc_en), 0);

        // held push gives one pulse; push outside RUN is dropped
        do_reset();
        svc_req = 4'b1000;
        tick(); tick();
        pulses = 0;
        push_m = 1'b1;
        repeat (3) begin tick(); if (push_out == 4'b1000) pulses++; else if (push_out != 0) pulses += 10; end
        push_m = 1'b0;
        repeat (3) begin tick(); if (push_out == 4'b1000) pulses++; else if (push_out != 0) pulses += 10; end
        chk("push held pulses", 32'(pulses), 1);
        svc_req = '0; tick(); tick();
        pulses = 0;
        push_m = 1'b1; tick();
        push_m = 1'b0;
        repeat (3) begin tick(); if (push_out != 0) pulses++; end
        chk("push idle pulses", 32'(pulses), 0);

        // asynchronous reset in the middle of RUN
        do_reset();
        svc_req = 4'b0010;
        tick(); tick(); tick();
        chk("pre-reset run", 32'(svc_en), 32'(4'b0010));
        #2 reset = 1'b1;
        #1;
        chk("async rst svc_en", 32'(svc_en), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst active_id", 32'(active_id), 0);
        chk("async rst push_out", 32'(push_out), 0);
        chk("async rst timeout_flag", 32'(timeout_flag), 0);
        svc_req = '0;
        reset = 1'b0;

        // randomized traffic against the reference model
        do_reset();
        model_init();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) svc_req = svc_req ^ (4'b0001 << $urandom_range(0, 3));
            finish      = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            push_m      = ($urandom_range(0, 2) == 0);
            alarm_armed = ($urandom_range(0, 3) != 0);
            current     = 16'($urandom_range(0, 15));
            model_step(svc_req, finish, push_m, alarm_armed, current, alarm);
            tick();
            chk("rnd svc_en", 32'(svc_en), 32'(e_en));
            chk("rnd push_out", 32'(push_out), 32'(e_push));
            chk("rnd busy", 32'(busy), 32'(e_busy));
            chk("rnd timeout_flag", 32'(timeout_flag), 32'(e_tf));
            if (e_busy) chk("rnd active_id", 32'(active_id), 32'(m_owner));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/service_scheduler.md
SERVICE_SCHEDULER -- requirements
Module: service_scheduler

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N_SVC, default 4, number of services arbitrated; service index 3 is the alarm service.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd1000, the maximum number of RUN cycles before forced release.
Ports (name, direction, width, meaning):
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 svc_req  input  N_SVC  per-service request switches (SPDT level), bit i requests service i.
REQ-006 finish  input  N_SVC  per-service done flags; only bit of the granted service is observed.
REQ-007 push_m  input  1  raw mode push button, synchronous level.
REQ-008 alarm_armed  input  1  alarm enable.
REQ-009 current  input  16  current time word.
REQ-010 alarm  input  16  alarm time word.
REQ-011 svc_en  output  N_SVC  one-hot enable to the granted service (drives its SPDTx input).
REQ-012 push_out  output  N_SVC  one-cycle push pulse routed to the granted service.
REQ-013 active_id  output  2  index of the granted service, valid while busy=1.
REQ-014 busy  output  1  high in GRANT and RUN.
REQ-015 timeout_flag  output  1  one-cycle pulse on forced release by timeout.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, RUN, DRAIN, encoded one-hot.
REQ-017 alarm_pending SHALL set on the first cycle where alarm_armed=1 and current==alarm after a cycle where they were unequal; it SHALL clear in the cycle service 3 enters GRANT.
REQ-018 IDLE: if alarm_pending, go to GRANT with id=3; else if svc_req!=0, go to GRANT with id chosen round-robin starting at last_id+1 mod N_SVC; else stay.
REQ-019 GRANT: lasts exactly one cycle, svc_en[id]=1, counter cleared, next RUN.
REQ-020 RUN: svc_en[id]=1; counter increments each cycle and saturates at TIMEOUT.
REQ-021 RUN exit to DRAIN, priority order: finish[id]=1; svc_req[id]=0; alarm_pending=1 and id!=3 (preemption); counter==TIMEOUT-1 (also pulse timeout_flag).
REQ-022 DRAIN: lasts exactly one cycle, svc_en=0, push_out=0, last_id<=id, next IDLE.
REQ-023 push_m SHALL be rising-edge detected; push_out[id] pulses one cycle, one cycle after the edge, only when the FSM is in RUN; edges outside RUN are dropped.
REQ-024 svc_en SHALL never have more than one bit set, and SHALL be zero for at least one cycle between two different grants.
REQ-025 Latency: svc_req rising in IDLE SHALL produce svc_en one cycle later.
REQ-026 Simultaneous finish and alarm match in the same RUN cycle: finish wins the exit; alarm_pending remains set and is served from the next IDLE.
REQ-027 Requests for bits at or above N_SVC SHALL be ignored; finish bits of non-granted services SHALL be ignored.

Reset
REQ-028 On reset: state=IDLE, svc_en=0, push_out=0, active_id=0, busy=0, timeout_flag=0, counter=0, last_id=N_SVC-1, alarm_pending=0, push edge register=0.
REQ-029 Reset asserted mid-RUN SHALL drop svc_en to 0 immediately (asynchronously), without passing through DRAIN.

Structure
REQ-030 State encodings, the service index constant ALARM_SVC=3 and the default TIMEOUT SHALL live in the shared project package.
REQ-031 Round-robin pick SHALL be a sub-module rr_picker (inputs req, last_id; output id, valid), purely combinational.

Verification
REQ-032 Reset, then svc_req=4'b0010 -> svc_en=4'b0010 one cycle later; finish[1]=1 -> svc_en=0 for one cycle, busy=0.
REQ-033 svc_req=4'b0011 held, finish each grant after 5 cycles -> grants alternate 0,1,0,1 with one idle-enable gap each.
REQ-034 Service 0 in RUN, alarm=16'd10, alarm_armed=1, current steps 9->10 -> DRAIN, then svc_en=4'b1000; alarm_pending=0.
REQ-035 Service 2 granted, never finishes, TIMEOUT=20 -> timeout_flag pulses at the 20th RUN cycle, svc_en=0 next cycle.
REQ-036 push_m held high 3 cycles during RUN of service 3 -> exactly one push_out[3] pulse; push_m pulse in IDLE -> no push_out.
REQ-037 Reset asserted during RUN -> all outputs at REQ-028 values in the same cycle.
